country_road_sensor: RTL

//   Vehicle-detection front end for the highway/country-road signal controller.

---
 rtl/country_road_sensor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/country_road_sensor.sv
// Country-road vehicle detection front end: loop-detector conditioning,
// queued-vehicle counting, request (X) generation with maximum-green and
// highway hold-off enforcement, and sticky lamp-conflict detection.
module country_road_sensor #(
    parameter int DEBOUNCE  = 3,
    parameter int CNT_W     = 4,
    parameter int MAX_GREEN = 20,
    parameter int HOLDOFF   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arr_raw,
    input  logic             dep_pulse,
    input  logic [2:0]       CNTRY,
    input  logic [2:0]       HGWY,
    output logic             X,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             conflict
);

    localparam int STAB_W = $clog2(DEBOUNCE + 1);
    localparam int GT_W   = $clog2(MAX_GREEN + 1);
    localparam int HO_W   = $clog2(HOLDOFF + 1);

    localparam logic [2:0] LAMP_RED    = 3'd0;
    localparam logic [2:0] LAMP_YELLOW = 3'd1;
    localparam logic [2:0] LAMP_GREEN  = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    logic              s1;
    logic              s2;
    logic              db;
    logic              db_q;
    logic [STAB_W-1:0] stab_cnt;
    logic              arrival;
    logic              departure;

    state_t            state;
    state_t            next_state;
    logic [GT_W-1:0]   green_tmr;
    logic [GT_W-1:0]   green_tmr_next;
    logic [HO_W-1:0]   hold_cnt;
    logic [HO_W-1:0]   hold_cnt_next;
    logic              hold_run;
    logic              hold_run_next;

    // Two-flop synchronizer, then accept a level change only after DEBOUNCE
    // consecutive samples disagree with the current debounced level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            db       <= 1'b0;
            db_q     <= 1'b0;
            stab_cnt <= '0;
        end else begin
            s1   <= arr_raw;
            s2   <= s1;
            db_q <= db;
            if (s2 != db) begin
                if (stab_cnt == STAB_W'(DEBOUNCE - 1)) begin
                    db       <= s2;
                    stab_cnt <= '0;
                end else begin
                    stab_cnt <= stab_cnt + STAB_W'(1);
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    // A departure only counts while the country road is actually moving.
    assign arrival   = db & ~db_q;
    assign departure = dep_pulse & ((CNTRY == LAMP_GREEN) | (CNTRY == LAMP_YELLOW));

    // Queue counter: saturating up on arrival, floored down on departure,
    // simultaneous events cancel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            queue_cnt <= '0;
        end else if (arrival && !departure && (queue_cnt != '1)) begin
            queue_cnt <= queue_cnt + CNT_W'(1);
        end else if (departure && !arrival && (queue_cnt != '0)) begin
            queue_cnt <= queue_cnt - CNT_W'(1);
        end
    end

    // State, timers and the registered request output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            green_tmr <= '0;
            hold_cnt  <= '0;
            hold_run  <= 1'b0;
            X         <= 1'b0;
        end else begin
            state     <= next_state;
            green_tmr <= green_tmr_next;
            hold_cnt  <= hold_cnt_next;
            hold_run  <= hold_run_next;
            X         <= (next_state == REQ) || (next_state == SERVE);
        end
    end

    // Next-state logic; HOLD first waits for country red, then runs HOLDOFF cycles.
    always_comb begin
        next_state     = state;
        green_tmr_next = green_tmr;
        hold_cnt_next  = hold_cnt;
        hold_run_next  = hold_run;
        case (state)
            IDLE: begin
                if (queue_cnt != '0) next_state = REQ;
            end
            REQ: begin
                if (CNTRY == LAMP_GREEN) begin
                    next_state     = SERVE;
                    green_tmr_next = '0;
                end else if (queue_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            SERVE: begin
                green_tmr_next = green_tmr + GT_W'(1);
                if (queue_cnt == '0) begin
                    next_state = IDLE;
                end else if (green_tmr == GT_W'(MAX_GREEN - 1)) begin
                    next_state    = HOLD;
                    hold_run_next = 1'b0;
                    hold_cnt_next = '0;
                end else if (CNTRY != LAMP_GREEN) begin
                    next_state = REQ;
                end
            end
            HOLD: begin
                if (!hold_run) begin
                    if (CNTRY == LAMP_RED) begin
                        hold_run_next = 1'b1;
                        hold_cnt_next = '0;
                    end
                end else if (hold_cnt == HO_W'(HOLDOFF - 1)) begin
                    next_state = (queue_cnt != '0) ? REQ : IDLE;
                end else begin
                    hold_cnt_next = hold_cnt + HO_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Sticky flag for both roads non-red or any undefined lamp code.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict <= 1'b0;
        end else if (((CNTRY != LAMP_RED) && (HGWY != LAMP_RED)) ||
                     (CNTRY > LAMP_GREEN) || (HGWY > LAMP_GREEN)) begin
            conflict <= 1'b1;
        end
    end

endmodule
